// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP multiplier.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         rnd_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic [3:0]   out_flags;

    modport master (
        output in_valid, in_a, in_b, rnd_mode, out_ready,
        input  in_ready, out_valid, out_res, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, rnd_mode, out_ready,
        output in_ready, out_valid, out_res, out_flags
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier (unpack/specials -> mantissa product -> normalise/round/pack), 3-cycle latency.
// Bubbles compress under stall, so in_ready drops only when all three stages hold data and out_ready is low.
module fp_mul_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input logic          clk,
    input logic          rst,
    fp_mul_pipe_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int PW    = 2 * MAN_W + 2;
    localparam int EW    = EXP_W + 2;
    localparam int NW    = EXP_W + $clog2(PW) + 3;
    localparam int LW    = $clog2(PW + 1);
    localparam int SHMAX = MAN_W + 3;
    localparam int BIAS  = 2 ** (EXP_W - 1) - 1;
    localparam logic [EXP_W-1:0] EMAX = '1;

    logic ld1, ld2, ld3;
    logic v1, v2, v3;

    logic           sg1, rm1, sp1;
    logic [EW-1:0]  e1;
    logic [MAN_W:0] ma1, mb1;
    logic [W-1:0]   spr1;
    logic [3:0]     spf1;

    logic           sg2, rm2, sp2;
    logic [EW-1:0]  e2;
    logic [PW-1:0]  p2;
    logic [W-1:0]   spr2;
    logic [3:0]     spf2;

    logic [W-1:0]   res3;
    logic [3:0]     flg3;

    assign ld3 = !v3 || bus.out_ready;
    assign ld2 = !v2 || ld3;
    assign ld1 = !v1 || ld2;
    assign bus.in_ready  = ld1;
    assign bus.out_valid = v3;
    assign bus.out_res   = res3;
    assign bus.out_flags = flg3;

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, zero_inf;
    logic             sp_c;
    logic [W-1:0]     spr_c;
    logic [3:0]       spf_c;
    logic [EW-1:0]    esum_c;

    assign {sa, ea, fa} = bus.in_a;
    assign {sb, eb, fb} = bus.in_b;
    assign ea_eff   = (ea == '0) ? EXP_W'(1) : ea;
    assign eb_eff   = (eb == '0) ? EXP_W'(1) : eb;
    assign a_nan    = (ea == EMAX) && (fa != '0);
    assign b_nan    = (eb == EMAX) && (fb != '0);
    assign a_inf    = (ea == EMAX) && (fa == '0);
    assign b_inf    = (eb == EMAX) && (fb == '0);
    assign a_zero   = (ea == '0) && (fa == '0);
    assign b_zero   = (eb == '0) && (fb == '0);
    assign zero_inf = (a_zero && b_inf) || (a_inf && b_zero);
    assign esum_c   = {2'b00, ea_eff} + {2'b00, eb_eff} - EW'(BIAS);

    always_comb begin
        sp_c  = 1'b1;
        spr_c = '0;
        spf_c = '0;
        if (a_nan || b_nan || zero_inf) begin
            spr_c = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
            spf_c = {zero_inf || (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]), 3'b000};
        end else if (a_inf || b_inf) begin
            spr_c = {sa ^ sb, EMAX, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            spr_c = {sa ^ sb, {(W-1){1'b0}}};
        end else begin
            sp_c = 1'b0;
        end
    end

    logic [LW-1:0]       lzc;
    logic                lz_done;
    logic [PW-1:0]       pn, dn;
    logic [NW-1:0]       en, shr, sh, base, epost;
    logic [2*PW-1:0]     wide;
    logic [MAN_W:0]      kept;
    logic [NW+MAN_W-1:0] sum;
    logic                tiny, g, r, s, inc, inx, ovf;
    logic [W-1:0]        res_c;
    logic [3:0]          flg_c;

    always_comb begin
        lzc     = '0;
        lz_done = 1'b0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (p2[i]) lz_done = 1'b1;
            else if (!lz_done) lzc = lzc + 1'b1;
        end
    end

    // en is the biased exponent once the leading one sits in the top product bit
    assign en   = {{(NW-EW){e2[EW-1]}}, e2} + NW'(1) - NW'(lzc);
    assign pn   = p2 << lzc;
    assign tiny = en[NW-1] || (en == '0);
    assign shr  = NW'(1) - en;
    assign sh   = !tiny ? NW'(0) : ((shr > NW'(SHMAX)) ? NW'(SHMAX) : shr);
    assign wide = {pn, {PW{1'b0}}} >> sh;
    assign dn   = wide[2*PW-1:PW];
    assign kept = dn[PW-1:MAN_W+1];
    assign g    = dn[MAN_W];
    assign r    = dn[MAN_W-1];
    assign s    = (|dn[MAN_W-2:0]) || (|wide[PW-1:0]);
    assign inx  = g || r || s;
    assign inc  = !rm2 && g && (r || s || kept[0]);
    // hidden bit and rounding carry ripple into the exponent field through this add
    assign base  = tiny ? '0 : en - NW'(1);
    assign sum   = {base, {MAN_W{1'b0}}} + (NW+MAN_W)'(kept) + (NW+MAN_W)'(inc);
    assign epost = sum[NW+MAN_W-1:MAN_W];
    assign ovf   = epost >= NW'(EMAX);

    always_comb begin
        res_c = {sg2, sum[EXP_W+MAN_W-1:0]};
        flg_c = {2'b00, tiny && inx, inx};
        if (ovf) begin
            res_c = rm2 ? {sg2, EMAX - EXP_W'(1), {MAN_W{1'b1}}} : {sg2, EMAX, {MAN_W{1'b0}}};
            flg_c = 4'b0101;
        end
        if (sp2) begin
            res_c = spr2;
            flg_c = spf2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0; sg1 <= 1'b0; rm1 <= 1'b0; sp1 <= 1'b0;
            e1 <= '0; ma1 <= '0; mb1 <= '0; spr1 <= '0; spf1 <= '0;
            v2 <= 1'b0; sg2 <= 1'b0; rm2 <= 1'b0; sp2 <= 1'b0;
            e2 <= '0; p2 <= '0; spr2 <= '0; spf2 <= '0;
            v3 <= 1'b0; res3 <= '0; flg3 <= '0;
        end else begin
            if (ld1) begin
                v1   <= bus.in_valid;
                sg1  <= sa ^ sb;
                rm1  <= bus.rnd_mode;
                sp1  <= sp_c;
                e1   <= esum_c;
                ma1  <= {ea != '0, fa};
                mb1  <= {eb != '0, fb};
                spr1 <= spr_c;
                spf1 <= spf_c;
            end
            if (ld2) begin
                v2   <= v1;
                sg2  <= sg1;
                rm2  <= rm1;
                sp2  <= sp1;
                e2   <= e1;
                p2   <= PW'(ma1) * PW'(mb1);
                spr2 <= spr1;
                spf2 <= spf1;
            end
            if (ld3) begin
                v3   <= v2;
                res3 <= res_c;
                flg3 <= flg_c;
            end
        end
    end
endmodule
